// File: rtl/mem1k32_ctrl_if.sv
// rtl/mem1k32_ctrl_if.sv - host command, write-data and read-data channels of mem1k32_ctrl
interface mem1k32_ctrl_if #(
   parameter int AddrWidth = 10,
   parameter int MemWidth  = 32,
   parameter int LenWidth  = 4
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [AddrWidth-1:0] cmd_addr;
   logic [LenWidth-1:0]  cmd_len;
   logic                 wr_data_valid;
   logic                 wr_data_ready;
   logic [MemWidth-1:0]  wr_data;
   logic                 rd_data_valid;
   logic                 rd_data_ready;
   logic [MemWidth-1:0]  rd_data;
   logic                 rd_data_perr;
   logic                 rd_data_last;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data_valid, wr_data, rd_data_ready,
      input  cmd_ready, wr_data_ready, rd_data_valid, rd_data, rd_data_perr, rd_data_last
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data_valid, wr_data, rd_data_ready,
      output cmd_ready, wr_data_ready, rd_data_valid, rd_data, rd_data_perr, rd_data_last
   );
endinterface

// File: rtl/mem1k32_ctrl.sv
// rtl/mem1k32_ctrl.sv - burst read/write controller for the 1k x 32 parity-protected RAM
module mem1k32_ctrl #(
   parameter int AddrWidth = 10,
   parameter int MemWidth  = 32,
   parameter int LenWidth  = 4,
   parameter int CntWidth  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem1k32_ctrl_if.slave        host,
   output logic                 busy,
   output logic [CntWidth-1:0]  err_parity_cnt,
   output logic                 err_protocol,
   input  logic                 err_clear,
   output logic                 mem_chip_en,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [MemWidth-1:0]  mem_data_o,
   input  logic [MemWidth-1:0]  mem_data_i,
   input  logic                 mem_valid,
   input  logic                 mem_parity_err
);
   typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP} state_t;

   state_t               state;
   logic [AddrWidth-1:0] cur_addr;
   logic [LenWidth-1:0]  remaining;
   logic [MemWidth-1:0]  rd_data_q;
   logic                 rd_perr_q;
   logic                 last_word;
   logic                 word_err;

   assign last_word = (remaining == '0);
   assign word_err  = mem_parity_err | ~mem_valid;

   assign host.cmd_ready     = (state == IDLE);
   assign host.wr_data_ready = (state == WR);
   assign host.rd_data_valid = (state == RD_RESP);
   assign host.rd_data_last  = (state == RD_RESP) && last_word;
   assign host.rd_data       = rd_data_q;
   assign host.rd_data_perr  = rd_perr_q;
   assign busy               = (state != IDLE);

   assign mem_read   = (state == RD_ISSUE);
   assign mem_write  = (state == WR) && host.wr_data_valid;
   assign mem_addr   = (state == WR || state == RD_ISSUE) ? cur_addr : '0;
   assign mem_data_o = (state == WR) ? host.wr_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cur_addr       <= '0;
         remaining      <= '0;
         rd_data_q      <= '0;
         rd_perr_q      <= 1'b0;
         err_parity_cnt <= '0;
         err_protocol   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host.cmd_valid) begin
                  cur_addr  <= host.cmd_addr;
                  remaining <= host.cmd_len;
                  state     <= host.cmd_write ? WR : RD_ISSUE;
               end
            end
            WR: begin
               if (host.wr_data_valid) begin
                  cur_addr  <= cur_addr + AddrWidth'(1);
                  remaining <= remaining - LenWidth'(1);
                  if (last_word) state <= IDLE;
               end
            end
            RD_ISSUE: state <= RD_CAPTURE;
            RD_CAPTURE: begin
               rd_data_q <= mem_data_i;
               rd_perr_q <= word_err;
               state     <= RD_RESP;
            end
            RD_RESP: begin
               if (host.rd_data_ready) begin
                  if (last_word) begin
                     state <= IDLE;
                  end else begin
                     cur_addr  <= cur_addr + AddrWidth'(1);
                     remaining <= remaining - LenWidth'(1);
                     state     <= RD_ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Clear wins over an update landing in the same cycle.
         if (err_clear) begin
            err_parity_cnt <= '0;
            err_protocol   <= 1'b0;
         end else if (state == RD_CAPTURE) begin
            if (!mem_valid) err_protocol <= 1'b1;
            if (word_err && err_parity_cnt != '1) err_parity_cnt <= err_parity_cnt + CntWidth'(1);
         end
      end
   end

   // The RAM gates its clock with ChipEn, so it may only change while clk is low.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) mem_chip_en <= 1'b0;
      else        mem_chip_en <= (state != IDLE);
   end
endmodule

// File: tb/tb_mem1k32_ctrl.sv
// tb/tb_mem1k32_ctrl.sv - scoreboard bench for mem1k32_ctrl with a gated-clock parity RAM model
module tb_mem1k32_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        err_clear = 1'b0;
   logic        busy, err_protocol;
   logic [7:0]  err_parity_cnt;
   logic        mem_chip_en, mem_read, mem_write, mem_valid, mem_parity_err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data_o, mem_data_i;

   mem1k32_ctrl_if ifc ();

   mem1k32_ctrl dut (
      .clk(clk), .rst_n(rst_n), .host(ifc), .busy(busy),
      .err_parity_cnt(err_parity_cnt), .err_protocol(err_protocol), .err_clear(err_clear),
      .mem_chip_en(mem_chip_en), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .mem_valid(mem_valid), .mem_parity_err(mem_parity_err)
   );

   always #5 clk = ~clk;

   // RAM model: data plus stored parity, clocked by clk gated with ChipEn
   logic [31:0]   ram_d [0:1023];
   logic          ram_p [0:1023];
   logic [1023:0] par_flip = '0;
   logic          ram_valid = 1'b0;
   logic          force_invalid = 1'b0;
   logic          ram_clk;
   assign ram_clk   = clk & mem_chip_en;
   assign mem_valid = ram_valid & ~force_invalid;

   always @(posedge ram_clk) begin
      ram_valid <= 1'b0;
      if (mem_write) begin
         ram_d[mem_addr] <= mem_data_o;
         ram_p[mem_addr] <= ^mem_data_o;
      end
      if (mem_read) begin
         mem_data_i     <= ram_d[mem_addr];
         mem_parity_err <= (^ram_d[mem_addr]) ^ ram_p[mem_addr] ^ par_flip[mem_addr];
         ram_valid      <= 1'b1;
      end
   end

   typedef struct { logic [31:0] d; logic perr; logic last; } rsp_t;
   typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
   rsp_t exp_rd[$];
   wr_t  exp_wr[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   chip_rises = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input logic [31:0] d, input logic perr, input logic last);
      rsp_t r;
      r.d = d; r.perr = perr; r.last = last;
      exp_rd.push_back(r);
   endtask

   // Monitor: samples mid-low-phase, pops write and read scoreboards
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         chk("rd_wr_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
         if (mem_write) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
            else begin
               chk("wr_addr", {54'd0, mem_addr}, {54'd0, exp_wr[0].a});
               chk("wr_data", {32'd0, mem_data_o}, {32'd0, exp_wr[0].d});
               void'(exp_wr.pop_front());
            end
         end
         if (ifc.rd_data_valid) begin
            chk("no_read_during_resp", {63'd0, mem_read}, 64'd0);
            if (exp_rd.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
            else begin
               chk("rd_data", {32'd0, ifc.rd_data}, {32'd0, exp_rd[0].d});
               chk("rd_perr", {63'd0, ifc.rd_data_perr}, {63'd0, exp_rd[0].perr});
               chk("rd_last", {63'd0, ifc.rd_data_last}, {63'd0, exp_rd[0].last});
               if (ifc.rd_data_ready) void'(exp_rd.pop_front());
            end
         end
      end
   end

   always @(mem_chip_en) begin
      if (rst_n === 1'b1) chk("chip_en_changes_clk_low", {63'd0, clk}, 64'd0);
   end
   always @(posedge mem_chip_en) chip_rises++;

   task automatic send_cmd(input logic w, input logic [9:0] a, input logic [3:0] l);
      int n = 0;
      @(negedge clk);
      while (!ifc.cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("cmd_ready_timeout", 64'd1, 64'd0);
      ifc.cmd_valid = 1'b1; ifc.cmd_write = w; ifc.cmd_addr = a; ifc.cmd_len = l;
      @(negedge clk);
      ifc.cmd_valid = 1'b0;
   endtask

   task automatic write_words(input logic [9:0] a, input logic [31:0] w [$], input bit gaps);
      wr_t e;
      send_cmd(1'b1, a, 4'(w.size() - 1));
      for (int i = 0; i < w.size(); i++) begin
         if (gaps && i > 0) begin
            ifc.wr_data_valid = 1'b0;
            repeat (2) @(negedge clk);
         end
         e.a = a + 10'(i); e.d = w[i];
         exp_wr.push_back(e);
         ifc.wr_data_valid = 1'b1; ifc.wr_data = w[i];
         @(negedge clk);
      end
      ifc.wr_data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); #2; n++; end
      while (!(ifc.cmd_ready && exp_rd.size() == 0 && exp_wr.size() == 0) && n < 200);
      if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
      @(negedge clk); #2;
   endtask

   initial begin
      int r0, n;
      ifc.cmd_valid = 0; ifc.cmd_write = 0; ifc.cmd_addr = 0; ifc.cmd_len = 0;
      ifc.wr_data_valid = 0; ifc.wr_data = 0; ifc.rd_data_ready = 1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk("rst_cmd_ready", {63'd0, ifc.cmd_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_chip_en", {63'd0, mem_chip_en}, 64'd0);
      chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
      chk("rst_rd_valid", {63'd0, ifc.rd_data_valid}, 64'd0);
      chk("rst_err_cnt", {56'd0, err_parity_cnt}, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // single write then read at the top address, with latency check
      write_words(10'h3FF, '{32'hDEADBEEF}, 1'b0);
      wait_idle();
      exp_push(32'hDEADBEEF, 1'b0, 1'b1);
      send_cmd(1'b0, 10'h3FF, 4'd0);
      #2;
      chk("lat_read_issue", {62'd0, mem_read, ifc.rd_data_valid}, 64'd2);
      @(negedge clk); #2;
      chk("lat_capture", {62'd0, mem_read, ifc.rd_data_valid}, 64'd0);
      @(negedge clk); #2;
      chk("lat_valid_e2", {63'd0, ifc.rd_data_valid}, 64'd1);
      wait_idle();

      // wrapping burst write and read back
      write_words(10'h3FE, '{32'h11, 32'h22, 32'h33, 32'h44}, 1'b0);
      wait_idle();
      exp_push(32'h11, 0, 0); exp_push(32'h22, 0, 0); exp_push(32'h33, 0, 0); exp_push(32'h44, 0, 1);
      send_cmd(1'b0, 10'h3FE, 4'd3);
      wait_idle();

      // backpressure on word 0 for 5 cycles
      ifc.rd_data_ready = 1'b0;
      r0 = chip_rises;
      exp_push(32'h11, 0, 0); exp_push(32'h22, 0, 1);
      send_cmd(1'b0, 10'h3FE, 4'd1);
      n = 0;
      do begin @(negedge clk); #2; n++; end while (!ifc.rd_data_valid && n < 20);
      if (n >= 20) chk("stall_valid_timeout", 64'd1, 64'd0);
      repeat (5) @(negedge clk);
      ifc.rd_data_ready = 1'b1;
      wait_idle();
      chk("chip_en_single_rise", 64'(chip_rises - r0), 64'd1);

      // injected parity error, then err_clear
      write_words(10'h010, '{32'h12345678}, 1'b0);
      wait_idle();
      par_flip[10'h010] = 1'b1;
      exp_push(32'h12345678, 1'b1, 1'b1);
      send_cmd(1'b0, 10'h010, 4'd0);
      wait_idle();
      chk("perr_cnt_1", {56'd0, err_parity_cnt}, 64'd1);
      chk("perr_no_protocol", {63'd0, err_protocol}, 64'd0);
      err_clear = 1'b1;
      @(negedge clk) err_clear = 1'b0;
      #2;
      chk("perr_cnt_cleared", {56'd0, err_parity_cnt}, 64'd0);

      // missing RAM Valid, sticky protocol error
      force_invalid = 1'b1;
      exp_push(32'h44, 1'b1, 1'b1);
      send_cmd(1'b0, 10'h001, 4'd0);
      wait_idle();
      force_invalid = 1'b0;
      chk("protocol_set", {63'd0, err_protocol}, 64'd1);
      chk("protocol_cnt", {56'd0, err_parity_cnt}, 64'd1);
      exp_push(32'h33, 1'b0, 1'b1);
      send_cmd(1'b0, 10'h000, 4'd0);
      wait_idle();
      chk("protocol_sticky", {63'd0, err_protocol}, 64'd1);

      // writes with valid gaps, then read back
      write_words(10'h100, '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003}, 1'b1);
      wait_idle();
      exp_push(32'hAAAA0001, 0, 0); exp_push(32'hAAAA0002, 0, 0); exp_push(32'hAAAA0003, 0, 1);
      send_cmd(1'b0, 10'h100, 4'd2);
      wait_idle();

      // reset during a read burst, in the capture cycle of word 1
      exp_push(32'h11, 0, 0); exp_push(32'h22, 0, 0); exp_push(32'h33, 0, 0); exp_push(32'h44, 0, 1);
      send_cmd(1'b0, 10'h3FE, 4'd3);
      repeat (4) @(negedge clk);
      chk("pre_rst_chip_en", {63'd0, mem_chip_en}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_chip_en", {63'd0, mem_chip_en}, 64'd0);
      chk("midrst_ready_busy", {62'd0, ifc.cmd_ready, busy}, 64'd2);
      chk("midrst_rd", {30'd0, ifc.rd_data_valid, ifc.rd_data_last, ifc.rd_data}, 64'd0);
      chk("midrst_errs", {55'd0, err_protocol, err_parity_cnt}, 64'd0);
      exp_rd.delete();
      @(negedge clk) rst_n = 1'b1;
      exp_push(32'h22, 1'b0, 1'b1);
      send_cmd(1'b0, 10'h3FF, 4'd0);
      wait_idle();

      chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
      chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/mem1k32_ctrl.md
Name: mem1k32_ctrl

Overview:
- Initiator-side controller for the 1k x 32 parity-protected single-port RAM.
- Accepts single or burst read/write commands from a host over valid/ready handshakes.
- Sequences the RAM's ChipEn/Read/Write/Addr/DataI pins and captures DataO with Valid and ParityErr.
- Returns read words with parity status and keeps error statistics. Sits between host logic and the RAM instance.

Parameters:
AddrWidth, 10, RAM address width; addresses wrap modulo 2^AddrWidth
MemWidth, 32, data word width
LenWidth, 4, burst length field; burst = cmd_len+1 words (1..16 default)
CntWidth, 8, parity-error counter width, saturating

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller idle, command accepted when valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  AddrWidth  burst start address
cmd_len  in  LenWidth  words minus one
wr_data_valid  in  1  write word valid
wr_data_ready  out  1  write word accepted (written to RAM this edge)
wr_data  in  MemWidth  write word
rd_data_valid  out  1  read word valid
rd_data_ready  in  1  host accepts read word
rd_data  out  MemWidth  read word
rd_data_perr  out  1  parity/protocol error on this word
rd_data_last  out  1  final word of burst
busy  out  1  not IDLE
err_parity_cnt  out  CntWidth  saturating count of erroneous read words
err_protocol  out  1  sticky: RAM Valid missing when expected
err_clear  in  1  sync clear of err_parity_cnt and err_protocol
mem_chip_en  out  1  to RAM ChipEn
mem_read  out  1  to RAM Read
mem_write  out  1  to RAM Write
mem_addr  out  AddrWidth  to RAM Addr
mem_data_o  out  MemWidth  to RAM DataI
mem_data_i  in  MemWidth  from RAM DataO
mem_valid  in  1  from RAM Valid
mem_parity_err  in  1  from RAM ParityErr

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 except cmd_ready=1. State IDLE, counters 0.
- Reset mid-burst: burst abandoned; no rd_data_last is issued; mem_chip_en drops immediately.
- States: IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/write into cur_addr and remaining; go to WR or RD_ISSUE.
- WR:
  - wr_data_ready=1.
  - mem_write=wr_data_valid, mem_read=0, mem_addr=cur_addr, mem_data_o=wr_data.
  - On each accepted word: cur_addr++ (wraps 0x3FF->0x000), remaining--.
  - After the last word, go to IDLE.
  - Gaps in wr_data_valid stall the burst with no RAM access.
- RD_ISSUE: mem_read=1, mem_write=0, mem_addr=cur_addr. The RAM latches at the end of this cycle. Next state is RD_CAPTURE.
- RD_CAPTURE:
  - mem_read=0, mem_write=0.
  - At the end of the cycle, register rd_data<=mem_data_i and rd_data_perr<=mem_parity_err|~mem_valid.
  - If mem_valid=0, set err_protocol.
  - If the word is erroneous, increment err_parity_cnt (saturating).
  - Go to RD_RESP.
- RD_RESP:
  - rd_data_valid=1; rd_data_last=1 when remaining==0. Data holds stable while rd_data_ready=0.
  - On handshake: if last, go to IDLE; else cur_addr++ (wrap), remaining--, go to RD_ISSUE.
- Latency: command accepted at edge E0 -> first mem_read during cycle E0..E1 -> rd_data_valid from E2. Each read word costs 3 cycles with no backpressure. Writes run at 1 word/cycle.
- mem_chip_en:
  - Driven from a falling-edge flop (async reset to 0), because the RAM gates its clock with ChipEn; a posedge-launched change could create a spurious RAM clock edge.
  - Set at the first negedge after leaving IDLE. Cleared at the first negedge after returning to IDLE.
  - Must never glitch.
- mem_read and mem_write are never 1 simultaneously. Both are 0 in IDLE.
- err_clear has priority over a same-cycle increment or set.

Test Plan:
- Write single 0xDEADBEEF at 0x3FF, then read 0x3FF -> rd_data=0xDEADBEEF, perr=0, last=1; rd_data_valid 2 cycles after read cmd accept.
- Write burst len=3 from 0x3FE with 0x11,0x22,0x33,0x44 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001. Read back the same burst -> identical data, last only on 4th word.
- Read burst len=1 with rd_data_ready low 5 cycles on word 0 -> rd_data held stable, no further mem_read until handshake. mem_chip_en has no glitches (check at sub-cycle resolution).
- Corrupt RAM parity bit at 0x010 via backdoor, read 0x010 -> rd_data_perr=1, err_parity_cnt=1. Pulse err_clear -> count 0.
- Force mem_valid=0 during RD_CAPTURE -> err_protocol=1 (sticky), rd_data_perr=1. Writes with wr_data_valid gaps -> mem_write only on valid cycles.
- Assert rst_n low mid read burst -> all outputs reset immediately, mem_chip_en=0. Then a new command runs normally.
